// File: rtl/div_gen.sv
// div_gen: sequential restoring divider, one quotient bit per cycle.
// Handles signed (two's-complement) and unsigned operands by dividing
// magnitudes and fixing signs when the result is registered.
// Build option: define DIV_ZERO_DETECT_EN to short-cut divide-by-zero through
// a BYZERO state (ready two cycles after acceptance, dz_o flagged). Without it
// a zero divisor runs the normal WIDTH-step sequence and dz_o is tied low.
module div_gen #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sign_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 dz_o
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef DIV_ZERO_DETECT_EN
    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_FREE = 2'd0,
        ST_ON   = 2'd2,
        ST_END  = 2'd3
    } state_e;
`endif

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;      // partial remainder
    logic [WIDTH-1:0]   dq_q, dq_d;        // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   dsr_q, dsr_d;      // divisor magnitude
    logic               dsr_zero_q, dsr_zero_d;
    logic               dvd_neg_q, dvd_neg_d;
    logic               dsr_neg_q, dsr_neg_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic               ready_q, ready_d;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor. The borrow (bit WIDTH) is only
    // meaningful while remainder < divisor holds, which a zero divisor breaks,
    // so a zero divisor always takes the subtract path.
    logic [WIDTH:0]     cur;
    logic [WIDTH:0]     sub;
    logic               ge;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   dq_step;
    logic [WIDTH-1:0]   quo_fin;
    logic [WIDTH-1:0]   rem_fin;
    logic               op1_neg;
    logic               op2_neg;
    logic [WIDTH-1:0]   op1_mag;
    logic [WIDTH-1:0]   op2_mag;

    assign cur      = {rem_q, dq_q[WIDTH-1]};
    assign sub      = cur - {1'b0, dsr_q};
    assign ge       = ~sub[WIDTH] | dsr_zero_q;
    assign rem_step = ge ? sub[WIDTH-1:0] : cur[WIDTH-1:0];
    assign dq_step  = {dq_q[WIDTH-2:0], ge};

    // Sign fix-up: quotient negative when signs differ, remainder follows dividend.
    assign quo_fin  = (dvd_neg_q ^ dsr_neg_q) ? -dq_q : dq_q;
    assign rem_fin  = dvd_neg_q ? -rem_q : rem_q;

    assign op1_neg  = sign_div_i & opdata1_i[WIDTH-1];
    assign op2_neg  = sign_div_i & opdata2_i[WIDTH-1];
    assign op1_mag  = op1_neg ? -opdata1_i : opdata1_i;
    assign op2_mag  = op2_neg ? -opdata2_i : opdata2_i;

`ifdef DIV_ZERO_DETECT_EN
    logic dz_q, dz_d;
    logic [WIDTH-1:0] dvd_orig;
    // dq_q is untouched in BYZERO, so it still holds the dividend magnitude.
    assign dvd_orig = dvd_neg_q ? -dq_q : dq_q;
    assign dz_o     = dz_q;
`else
    assign dz_o     = 1'b0;
`endif

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dq_d       = dq_q;
        dsr_d      = dsr_q;
        dsr_zero_d = dsr_zero_q;
        dvd_neg_d  = dvd_neg_q;
        dsr_neg_d  = dsr_neg_q;
        res_d      = res_q;
        ready_d    = ready_q;
`ifdef DIV_ZERO_DETECT_EN
        dz_d       = dz_q;
`endif
        case (state_q)
            ST_FREE: begin
                if (start_i && !annul_i) begin
                    dq_d       = op1_mag;
                    dsr_d      = op2_mag;
                    rem_d      = '0;
                    cnt_d      = '0;
                    dvd_neg_d  = op1_neg;
                    dsr_neg_d  = op2_neg;
                    dsr_zero_d = (opdata2_i == '0);
`ifdef DIV_ZERO_DETECT_EN
                    state_d    = (opdata2_i == '0) ? ST_BYZERO : ST_ON;
`else
                    state_d    = ST_ON;
`endif
                end
            end
`ifdef DIV_ZERO_DETECT_EN
            // Two cycles here so ready appears at the same offset from the
            // last internal state as on the normal path.
            ST_BYZERO: begin
                if (annul_i) begin
                    state_d = ST_FREE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(1)) begin
                    state_d = ST_END;
                    res_d   = {dvd_orig, {WIDTH{1'b1}}};
                    ready_d = 1'b1;
                    dz_d    = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
`endif
            ST_ON: begin
                if (annul_i) begin
                    state_d = ST_FREE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(WIDTH)) begin
                    state_d = ST_END;
                    res_d   = {rem_fin, quo_fin};
                    ready_d = 1'b1;
                end else begin
                    rem_d   = rem_step;
                    dq_d    = dq_step;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            ST_END: begin
                // Requester holds start_i until it has seen ready; its drop
                // releases the result.
                if (!start_i) begin
                    state_d = ST_FREE;
                    res_d   = '0;
                    ready_d = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
                    dz_d    = 1'b0;
`endif
                end
            end
            default: begin
                state_d = ST_FREE;
                cnt_d   = '0;
                res_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FREE;
            cnt_q      <= '0;
            rem_q      <= '0;
            dq_q       <= '0;
            dsr_q      <= '0;
            dsr_zero_q <= 1'b0;
            dvd_neg_q  <= 1'b0;
            dsr_neg_q  <= 1'b0;
            res_q      <= '0;
            ready_q    <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            dz_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            dq_q       <= dq_d;
            dsr_q      <= dsr_d;
            dsr_zero_q <= dsr_zero_d;
            dvd_neg_q  <= dvd_neg_d;
            dsr_neg_q  <= dsr_neg_d;
            res_q      <= res_d;
            ready_q    <= ready_d;
`ifdef DIV_ZERO_DETECT_EN
            dz_q       <= dz_d;
`endif
        end
    end

    assign result_o = res_q;
    assign ready_o  = ready_q;
`ifdef DIV_ZERO_DETECT_EN
    assign busy_o   = (state_q == ST_ON) || (state_q == ST_BYZERO);
`else
    assign busy_o   = (state_q == ST_ON);
`endif

endmodule

// File: doc/div_gen.md
DIV_GEN -- requirements
Module: div_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width in bits (legal range 4..64).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port sign_div_i  input  1  1 = signed two's-complement divide, 0 = unsigned.
REQ-005 SHALL have port opdata1_i  input  WIDTH  dividend.
REQ-006 SHALL have port opdata2_i  input  WIDTH  divisor.
REQ-007 SHALL have port start_i  input  1  request; held high by requester until ready_o is seen.
REQ-008 SHALL have port annul_i  input  1  abort the operation in progress.
REQ-009 SHALL have port result_o  output  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}.
REQ-010 SHALL have port ready_o  output  1  result_o valid.
REQ-011 SHALL have port busy_o  output  1  iteration in progress.
REQ-012 SHALL have port dz_o  output  1  divide-by-zero detected, valid with ready_o.

Function
REQ-013 SHALL implement FSM states FREE, BYZERO (only when REQ-027 applies), ON, END.
REQ-014 In FREE with start_i=1 and annul_i=0, SHALL capture the operands, sign_div_i and divisor-zero status at that edge, clear the iteration counter, and move to ON. Later input changes are ignored.
REQ-015 In ON, SHALL perform one restoring-division step per cycle on operand magnitudes: quotient bit = 1 when partial remainder >= |divisor|. SHALL use a (WIDTH+1)-bit subtractor and a counter of width clog2(WIDTH+1).
REQ-016 After exactly WIDTH steps, SHALL move to END and register result_o.
REQ-017 Latency: start_i sampled at edge E gives ready_o=1 from edge E+WIDTH+1.
REQ-018 Signed mode: quotient SHALL be negated when operand signs differ; remainder SHALL carry the dividend's sign.
REQ-019 Signed overflow: (-2^(W-1)) / (-1) SHALL give quotient 2^(W-1) bit pattern (wraps) and remainder 0, with no flag.
REQ-020 In END, SHALL hold ready_o=1 and result_o stable while start_i=1. On the first cycle with start_i=0, SHALL return to FREE with ready_o=0 on the next edge. A new start SHALL NOT be accepted in END.
REQ-021 annul_i=1 in ON or BYZERO SHALL return to FREE on the next edge and SHALL NOT assert ready_o. annul_i in FREE SHALL block acceptance. annul_i in END SHALL be ignored.
REQ-022 busy_o SHALL be 1 exactly in ON and BYZERO.
REQ-023 result_o SHALL be 0 whenever ready_o=0.

Reset
REQ-024 rst=1 SHALL immediately force FREE, counter 0, result_o=0, ready_o=0, busy_o=0, dz_o=0, at any time including mid-operation.
REQ-025 After rst is released, the block SHALL accept start_i on the first rising edge.

Configuration
REQ-026 Macro DIV_ZERO_DETECT_EN SHALL select the divide-by-zero behaviour.
REQ-027 With DIV_ZERO_DETECT_EN defined: divisor 0 at acceptance SHALL go FREE->BYZERO->END, giving ready_o from edge E+2. Result SHALL be quotient all-ones and remainder = opdata1 (sign-independent), with dz_o=1 while ready_o=1.
REQ-028 Without DIV_ZERO_DETECT_EN: the BYZERO state SHALL be absent and dz_o SHALL be tied 0. Divisor 0 SHALL run the full WIDTH steps. Unsigned result: quotient all-ones, remainder = dividend. Signed result: quotient all-ones if dividend >= 0, else 1; remainder = dividend.

Verification (WIDTH=32)
REQ-029 Unsigned: 100 / 7 -> result_o = {0x00000002, 0x0000000E}, ready_o at edge E+33.
REQ-030 Signed: -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-031 Divisor 0, dividend 5, unsigned: with macro -> ready_o at E+2, dz_o=1, {5, 0xFFFFFFFF}. Without macro -> ready_o at E+33, dz_o=0, same result.
REQ-032 annul_i pulsed at cycle 10 of ON -> FREE, ready_o never asserts; a new start accepted next cycle completes correctly.
REQ-033 start_i held 5 cycles after ready_o -> result stable, no restart. start_i dropped -> ready_o=0 and result_o=0 one edge later.
REQ-034 rst asserted mid-ON (between edges) -> outputs zero immediately, FREE; a following 1/1 divide returns {0, 1}.
